// File: rtl/mips32_mem_loader.sv
// Program loader / result dumper for a MIPS32 core: streams words into core memory, pulses core_init,
// waits for HALTED, then streams a memory window out. Define MIPS32_LOADER_TIMEOUT_EN for a RUN watchdog.
module mips32_mem_loader #(
  parameter int ADDR_W      = 10,
  parameter int RUN_TIMEOUT = 4095
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [31:0]       in_data,
  input  logic [ADDR_W-1:0] dump_base,
  input  logic [ADDR_W-1:0] dump_len,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              core_init,
  input  logic              core_halted,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [31:0]       out_data,
  output logic              busy,
  output logic              done,
  output logic              timeout
);
  localparam int RUN_CW = $clog2(RUN_TIMEOUT + 1) + 1;
  localparam logic [ADDR_W-1:0] ONE     = 1;
  localparam logic [RUN_CW-1:0] RUN_ONE = 1;
`ifdef MIPS32_LOADER_TIMEOUT_EN
  localparam logic [RUN_CW-1:0] RUN_LIMIT = RUN_CW'(RUN_TIMEOUT - 1);
`endif

  typedef enum logic [2:0] {IDLE, LOAD, INIT, RUN, DUMP_RD, DUMP_OUT, DONE} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] load_cnt_reg, load_cnt_next;
  logic [ADDR_W-1:0] base_reg, base_next;
  logic [ADDR_W-1:0] len_reg, len_next;
  logic [ADDR_W-1:0] ptr_reg, ptr_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;
  logic [RUN_CW-1:0] run_cnt_reg, run_cnt_next;
  logic [31:0]       data_reg, data_next;
  logic              captured_reg, captured_next;
  logic              is_last;
  logic              leave_run;
`ifdef MIPS32_LOADER_TIMEOUT_EN
  logic              timeout_reg, timeout_next;
`endif

  assign is_last = (idx_reg == len_reg - ONE);

  always_comb begin
    state_next    = state_reg;
    load_cnt_next = load_cnt_reg;
    base_next     = base_reg;
    len_next      = len_reg;
    ptr_next      = ptr_reg;
    idx_next      = idx_reg;
    run_cnt_next  = run_cnt_reg;
    data_next     = data_reg;
    captured_next = captured_reg;
`ifdef MIPS32_LOADER_TIMEOUT_EN
    timeout_next  = timeout_reg;
`endif
    leave_run = 1'b0;
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    core_init = 1'b0;

    case (state_reg)
      IDLE, LOAD: begin
        in_ready = 1'b1;
        mem_addr = load_cnt_reg;
        if (in_valid) begin
          mem_we        = 1'b1;
          mem_wdata     = in_data;
          load_cnt_next = load_cnt_reg + ONE;
          state_next    = LOAD;
          if (in_last) begin
            base_next     = dump_base;
            len_next      = dump_len;
            load_cnt_next = '0;
            state_next    = INIT;
          end
        end
      end
      INIT: begin
        core_init    = 1'b1;
        run_cnt_next = '0;
        state_next   = RUN;
      end
      RUN: begin
        // Saturating count; a zero count marks the first RUN cycle, where a stale HALTED is ignored.
        if (!(&run_cnt_reg)) run_cnt_next = run_cnt_reg + RUN_ONE;
        if ((run_cnt_reg != '0) && core_halted) leave_run = 1'b1;
`ifdef MIPS32_LOADER_TIMEOUT_EN
        else if (run_cnt_reg >= RUN_LIMIT) begin
          timeout_next = 1'b1;
          leave_run    = 1'b1;
        end
`endif
        if (leave_run) begin
          ptr_next      = base_reg;
          idx_next      = '0;
          captured_next = 1'b0;
          state_next    = (len_reg == '0) ? DONE : DUMP_RD;
        end
      end
      DUMP_RD: begin
        mem_addr      = ptr_reg;
        captured_next = 1'b0;
        state_next    = DUMP_OUT;
      end
      DUMP_OUT: begin
        // Read data arrives one cycle after the address, so the first DUMP_OUT cycle captures it.
        mem_addr = ptr_reg;
        if (!captured_reg) begin
          data_next     = mem_rdata;
          captured_next = 1'b1;
        end else if (out_ready) begin
          if (is_last) begin
            state_next = DONE;
          end else begin
            ptr_next   = ptr_reg + ONE;
            idx_next   = idx_reg + ONE;
            state_next = DUMP_RD;
          end
        end
      end
      DONE: begin
        if (in_valid) begin
          state_next    = IDLE;
          load_cnt_next = '0;
`ifdef MIPS32_LOADER_TIMEOUT_EN
          timeout_next  = 1'b0;
`endif
        end
      end
      default: state_next = IDLE;
    endcase

    // Reset wins over a same-cycle handshake: no write may reach memory.
    if (rst) begin
      in_ready  = 1'b1;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      core_init = 1'b0;
    end
  end

  always_comb begin
    out_valid = (state_reg == DUMP_OUT) && captured_reg;
    out_last  = (state_reg == DUMP_OUT) && captured_reg && is_last;
    out_data  = data_reg;
    busy      = (state_reg != IDLE) && (state_reg != DONE);
    done      = (state_reg == DONE);
    if (rst) begin
      out_valid = 1'b0;
      out_last  = 1'b0;
      out_data  = '0;
      busy      = 1'b0;
      done      = 1'b0;
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_reg    <= IDLE;
      load_cnt_reg <= '0;
      base_reg     <= '0;
      len_reg      <= '0;
      ptr_reg      <= '0;
      idx_reg      <= '0;
      run_cnt_reg  <= '0;
      data_reg     <= '0;
      captured_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      load_cnt_reg <= load_cnt_next;
      base_reg     <= base_next;
      len_reg      <= len_next;
      ptr_reg      <= ptr_next;
      idx_reg      <= idx_next;
      run_cnt_reg  <= run_cnt_next;
      data_reg     <= data_next;
      captured_reg <= captured_next;
    end
  end

`ifdef MIPS32_LOADER_TIMEOUT_EN
  always_ff @(posedge clk1) begin
    if (rst) timeout_reg <= 1'b0;
    else     timeout_reg <= timeout_next;
  end

  assign timeout = timeout_reg & ~rst;
`else
  assign timeout = 1'b0;
`endif

endmodule
